// File: rtl/burst_ram_pkg.sv
// rtl/burst_ram_pkg.sv - shared types and widths for the burst RAM responder
//
// Purpose: FSM state encoding and beat/mask widths used by burst_ram_responder
//          and burst_ram_array.
// Ports:   none (package).

package burst_ram_pkg;

    localparam int BeatBitWidth = 64;
    localparam int MaskBitWidth = 8;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_WAIT,
        RD_BURST,
        WRITE
    } state_e;

endpackage

// File: rtl/burst_ram_array.sv
// rtl/burst_ram_array.sv - single-port 64-bit block RAM with byte enables
//
// Purpose: 2**AddressBitWidth x 64-bit storage, registered read (read-first).
// Ports:
//   i_clk      clock
//   i_we       write enable for this cycle
//   i_addr     word address, shared by read and write
//   i_wr_data  write word
//   i_byte_en  per-byte write enable, bit i covers i_wr_data[8i+7:8i]
//   o_rd_data  word at the address presented on the previous cycle

module burst_ram_array
    import burst_ram_pkg::*;
#(
    parameter int    AddressBitWidth = 10,
    parameter string DataFilePath    = ""
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [AddressBitWidth-1:0] i_addr,
    input  logic [BeatBitWidth-1:0]    i_wr_data,
    input  logic [MaskBitWidth-1:0]    i_byte_en,
    output logic [BeatBitWidth-1:0]    o_rd_data
);

    logic [BeatBitWidth-1:0] r_mem [2**AddressBitWidth];
    logic [BeatBitWidth-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < MaskBitWidth; b++) begin
                if (i_byte_en[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
        r_rd_data <= r_mem[i_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/burst_ram_responder.sv
// rtl/burst_ram_responder.sv - burst RAM target with PSRAM-like timing
//
// Purpose: accepts read/write burst commands of BurstDataCount 64-bit beats,
//          models calibration delay and fixed read latency over block RAM.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_cmd, i_cmd_en     0 read / 1 write, command valid
//   i_addr              first 64-bit word of the burst
//   i_wr_data           write beat (beat 0 on the command cycle)
//   i_data_mask         per-byte mask, 1 = byte not written
//   o_rd_data           read beat, zero when o_rd_data_valid is low
//   o_rd_data_valid     high for BurstDataCount cycles per read
//   o_busy              command in progress (also high during INIT)
//   o_init_calib        initialisation delay has elapsed
//   o_cmd_error         sticky: command issued while busy or uncalibrated

module burst_ram_responder
    import burst_ram_pkg::*;
#(
    parameter int    AddressBitWidth       = 10,
    parameter int    BurstDataCount        = 4,
    parameter int    CyclesBeforeDataValid = 6,
    parameter int    CyclesBeforeInitiated = 10,
    parameter string DataFilePath          = ""
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd,
    input  logic                       i_cmd_en,
    input  logic [AddressBitWidth-1:0] i_addr,
    input  logic [BeatBitWidth-1:0]    i_wr_data,
    input  logic [MaskBitWidth-1:0]    i_data_mask,
    output logic [BeatBitWidth-1:0]    o_rd_data,
    output logic                       o_rd_data_valid,
    output logic                       o_busy,
    output logic                       o_init_calib,
    output logic                       o_cmd_error
);

    localparam logic [15:0] InitLast = 16'(CyclesBeforeInitiated - 1);
    // The array read is registered, so the wait ends one cycle early.
    localparam logic [15:0] WaitLast = 16'(CyclesBeforeDataValid - 2);
    localparam logic [15:0] BeatLast = 16'(BurstDataCount - 1);

    generate
        if (CyclesBeforeDataValid < 2 || BurstDataCount < 1) begin : g_param_check
            $error("burst_ram_responder: need CyclesBeforeDataValid>=2 and BurstDataCount>=1");
        end
    endgenerate

    state_e                     r_state;
    logic [15:0]                r_cnt;
    logic [AddressBitWidth-1:0] r_ptr;
    logic                       r_rd_valid;
    logic                       r_busy;
    logic                       r_init_calib;
    logic                       r_cmd_error;

    logic                       w_accept;
    logic                       w_we;
    logic [AddressBitWidth-1:0] w_addr;
    logic [BeatBitWidth-1:0]    w_rd_q;

    assign w_accept = i_cmd_en && (r_state == IDLE);
    // Beat 0 is written in the command cycle itself; reset suppresses the current beat.
    assign w_we     = !i_rst && ((w_accept && i_cmd) || (r_state == WRITE));
    assign w_addr   = (r_state == IDLE) ? i_addr : r_ptr;

    burst_ram_array #(
        .AddressBitWidth (AddressBitWidth),
        .DataFilePath    (DataFilePath)
    ) u_array (
        .i_clk     (i_clk),
        .i_we      (w_we),
        .i_addr    (w_addr),
        .i_wr_data (i_wr_data),
        .i_byte_en (~i_data_mask),
        .o_rd_data (w_rd_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= INIT;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_rd_valid   <= 1'b0;
            r_busy       <= 1'b1;
            r_init_calib <= 1'b0;
            r_cmd_error  <= 1'b0;
        end else begin
            if (i_cmd_en && (r_state != IDLE)) begin
                r_cmd_error <= 1'b1;
            end
            case (r_state)
                INIT: begin
                    if (r_cnt == InitLast) begin
                        r_init_calib <= 1'b1;
                        r_busy       <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (i_cmd_en) begin
                        if (i_cmd) begin
                            r_ptr <= i_addr + 1'b1;
                            if (BurstDataCount > 1) begin
                                r_cnt   <= 16'd1;
                                r_busy  <= 1'b1;
                                r_state <= WRITE;
                            end
                        end else begin
                            r_ptr   <= i_addr;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // r_ptr is on the array address now; step it so the
                    // pointer stays one beat ahead of the output.
                    if (r_cnt == WaitLast) begin
                        r_rd_valid <= 1'b1;
                        r_ptr      <= r_ptr + 1'b1;
                        r_cnt      <= '0;
                        r_state    <= RD_BURST;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RD_BURST: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_cnt == BeatLast) begin
                        r_rd_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_cnt == BeatLast) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign o_rd_data       = r_rd_valid ? w_rd_q : '0;
    assign o_rd_data_valid = r_rd_valid;
    assign o_busy          = r_busy;
    assign o_init_calib    = r_init_calib;
    assign o_cmd_error     = r_cmd_error;

endmodule

// File: tb/tb_burst_ram_responder.sv
// tb/tb_burst_ram_responder.sv - scoreboard bench for burst_ram_responder

module tb_burst_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd;
    logic        cmd_en;
    logic [9:0]  addr;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        init_calib;
    logic        cmd_error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] mem_m [1024];
    logic [63:0] beats [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    burst_ram_responder dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_cmd           (cmd),
        .i_cmd_en        (cmd_en),
        .i_addr          (addr),
        .i_wr_data       (wr_data),
        .i_data_mask     (data_mask),
        .o_rd_data       (rd_data),
        .o_rd_data_valid (rd_valid),
        .o_busy          (busy),
        .o_init_calib    (init_calib),
        .o_cmd_error     (cmd_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = m[b] ? o[8*b +: 8] : n[8*b +: 8];
        return r;
    endfunction

    // Read monitor: every valid beat must match the oldest expectation, in data and cycle.
    always @(negedge clk) begin
        if (rd_valid) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_rd_valid: observed valid=1 expected no pending read");
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", rd_data, e.data);
                chk("rd_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 64'(busy), 64'(0));
    endtask

    task automatic reset_init(input bit poke);
        rst = 1'b1;
        cmd_en = 1'b0;
        tick();
        tick();
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_valid", 64'(rd_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(1));
        chk("rst_init", 64'(init_calib), 64'(0));
        chk("rst_cmd_error", 64'(cmd_error), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("init_low", 64'(init_calib), 64'(0));
            chk("init_busy", 64'(busy), 64'(1));
            if (poke && i == 3) begin
                cmd = 1'b0;
                cmd_en = 1'b1;
                addr = 10'h10;
            end
            tick();
            cmd_en = 1'b0;
        end
        chk("init_high", 64'(init_calib), 64'(1));
        chk("init_busy_low", 64'(busy), 64'(0));
        chk("init_cmd_error", 64'(cmd_error), 64'(poke));
    endtask

    task automatic do_write(input logic [9:0] a, input logic [63:0] d [4], input logic [7:0] m);
        wait_idle("wr_idle");
        cmd = 1'b1;
        cmd_en = 1'b1;
        addr = a;
        wr_data = d[0];
        data_mask = m;
        tick();
        cmd_en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            chk("wr_busy", 64'(busy), 64'(1));
            wr_data = d[k];
            tick();
        end
        chk("wr_busy_drop", 64'(busy), 64'(0));
        for (int k = 0; k < 4; k++) begin
            logic [9:0] ix;
            ix = a + 10'(k);
            mem_m[ix] = merge(mem_m[ix], d[k], m);
        end
    endtask

    task automatic start_read(input logic [9:0] a);
        wait_idle("rd_idle");
        cmd = 1'b0;
        cmd_en = 1'b1;
        addr = a;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            logic [9:0] ix;
            ix = a + 10'(k);
            e.data = mem_m[ix];
            e.cyc = cyc + 6 + k;
            sb.push_back(e);
        end
        tick();
        cmd_en = 1'b0;
    endtask

    task automatic wait_read_done(input string tag);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 64'(sb.size()), 64'(0));
        chk({tag, "_valid_low"}, 64'(rd_valid), 64'(0));
        chk({tag, "_data_zero"}, rd_data, 64'h0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        cmd = 1'b0;
        cmd_en = 1'b0;
        addr = '0;
        wr_data = '0;
        data_mask = '0;

        // 1: reset release, calibration delay, command during INIT
        reset_init(1'b1);

        // 2: full write then read-back with latency
        beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        do_write(10'h010, beats, 8'h00);
        start_read(10'h010);
        wait_read_done("rd_0x10");

        // 3: masked write keeps the upper four bytes
        beats = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        do_write(10'h020, beats, 8'h00);
        beats = '{64'h0, 64'h0, 64'h0, 64'h0};
        do_write(10'h020, beats, 8'hF0);
        start_read(10'h020);
        wait_read_done("rd_masked");

        // 4: burst wraps at the top of the array
        beats = '{64'hA0A0_0000_0000_0001, 64'hA1A1_0000_0000_0002,
                  64'hA2A2_0000_0000_0003, 64'hA3A3_0000_0000_0004};
        do_write(10'h3FE, beats, 8'h00);
        start_read(10'h3FE);
        wait_read_done("rd_wrap");

        // 6: reset during beat 2 of a write
        beats = '{64'h5555_0000_0000_0000, 64'h5555_0000_0000_0001,
                  64'h5555_0000_0000_0002, 64'h5555_0000_0000_0003};
        do_write(10'h040, beats, 8'h00);
        wait_idle("rst_wr_idle");
        cmd = 1'b1;
        cmd_en = 1'b1;
        addr = 10'h040;
        data_mask = 8'h00;
        wr_data = 64'h6666_0000_0000_0000;
        tick();
        cmd_en = 1'b0;
        wr_data = 64'h6666_0000_0000_0001;
        tick();
        wr_data = 64'h6666_0000_0000_0002;
        rst = 1'b1;
        tick();
        chk("midrst_busy", 64'(busy), 64'(1));
        chk("midrst_init", 64'(init_calib), 64'(0));
        chk("midrst_valid", 64'(rd_valid), 64'(0));
        mem_m[10'h040] = 64'h6666_0000_0000_0000;
        mem_m[10'h041] = 64'h6666_0000_0000_0001;
        reset_init(1'b0);
        start_read(10'h040);
        wait_read_done("rd_after_rst");

        // 5: command during a read is dropped and flagged
        chk("pre_collide_err", 64'(cmd_error), 64'(0));
        start_read(10'h010);
        tick();
        cmd = 1'b1;
        cmd_en = 1'b1;
        addr = 10'h010;
        wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        data_mask = 8'h00;
        tick();
        cmd_en = 1'b0;
        chk("collide_err", 64'(cmd_error), 64'(1));
        chk("collide_busy", 64'(busy), 64'(1));
        wait_read_done("rd_collide");
        start_read(10'h010);
        wait_read_done("rd_intact");
        chk("err_sticky", 64'(cmd_error), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
